// File: rtl/key_pkg.sv
// Shared state encoding, default timing constants and counter sizing for the key debouncer.
package key_pkg;

   typedef enum logic [1:0] {
      StReleased,
      StPressWait,
      StHeld,
      StReleaseWait
   } key_state_e;

   localparam int unsigned DEF_N_KEYS          = 4;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
   localparam int unsigned DEF_REPEAT_DELAY    = 25_000_000;
   localparam int unsigned DEF_REPEAT_PERIOD   = 10_000_000;
   localparam int unsigned DEF_REPEAT_EN       = 1;

   // Counters only ever hold (largest cycle parameter - 1), so clog2 of the largest is enough.
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                             input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m <= 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/key_channel.sv
// One push-button channel: 2-flop synchronizer, debounce FSM and auto-repeat timer.
module key_channel
   import key_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
   parameter int unsigned REPEAT_EN       = DEF_REPEAT_EN
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_key_n,
   output logic o_pressed,
   output logic o_press_pulse,
   output logic o_release_pulse,
   output logic o_step
);

   localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
   // The entry cycle into a wait state already counts as one stable sample.
   localparam bit DEB_DIRECT = (DEBOUNCE_CYCLES <= 1);
   localparam logic [CW-1:0] DEB_LAST =
      CW'((DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0);
   localparam logic [CW-1:0] REP_DELAY_LAST =
      CW'((REPEAT_DELAY >= 1) ? REPEAT_DELAY - 1 : 0);
   localparam logic [CW-1:0] REP_PERIOD_LAST =
      CW'((REPEAT_PERIOD >= 1) ? REPEAT_PERIOD - 1 : 0);

   logic       r_sync1, r_sync2;
   key_state_e r_state, w_state_d;
   logic [CW-1:0] r_cnt, w_cnt_d, w_cnt_inc;
   logic [CW-1:0] r_rep, w_rep_d, w_rep_inc;
   logic       r_rep_first, w_rep_first_d;
   logic       r_pressed, w_pressed_d;
   logic       r_press_pulse, w_press_pulse_d;
   logic       r_release_pulse, w_release_pulse_d;
   logic       r_step, w_step_d;
   logic       w_key;

   assign w_key     = ~r_sync2;
   assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
   assign w_rep_inc = (r_rep == '1) ? r_rep : r_rep + 1'b1;

   always_comb begin
      w_state_d         = r_state;
      w_cnt_d           = r_cnt;
      w_rep_d           = r_rep;
      w_rep_first_d     = r_rep_first;
      w_pressed_d       = r_pressed;
      w_press_pulse_d   = 1'b0;
      w_release_pulse_d = 1'b0;
      w_step_d          = 1'b0;
      unique case (r_state)
         StReleased: begin
            if (w_key) begin
               if (DEB_DIRECT) begin
                  w_state_d       = StHeld;
                  w_pressed_d     = 1'b1;
                  w_press_pulse_d = 1'b1;
                  w_step_d        = 1'b1;
                  w_rep_d         = '0;
                  w_rep_first_d   = 1'b1;
               end else begin
                  w_state_d = StPressWait;
                  w_cnt_d   = '0;
               end
            end
         end
         StPressWait: begin
            if (!w_key) begin
               w_state_d = StReleased;
            end else if (r_cnt >= DEB_LAST) begin
               w_state_d       = StHeld;
               w_pressed_d     = 1'b1;
               w_press_pulse_d = 1'b1;
               w_step_d        = 1'b1;
               w_rep_d         = '0;
               w_rep_first_d   = 1'b1;
            end else begin
               w_cnt_d = w_cnt_inc;
            end
         end
         StHeld: begin
            if (!w_key) begin
               if (DEB_DIRECT) begin
                  w_state_d         = StReleased;
                  w_pressed_d       = 1'b0;
                  w_release_pulse_d = 1'b1;
               end else begin
                  w_state_d = StReleaseWait;
                  w_cnt_d   = '0;
               end
            end else if (REPEAT_EN != 0) begin
               if (r_rep >= (r_rep_first ? REP_DELAY_LAST : REP_PERIOD_LAST)) begin
                  w_step_d      = 1'b1;
                  w_rep_d       = '0;
                  w_rep_first_d = 1'b0;
               end else begin
                  w_rep_d = w_rep_inc;
               end
            end
         end
         StReleaseWait: begin
            if (w_key) begin
               // Bounce back to held: repeat timing starts over from the delay.
               w_state_d     = StHeld;
               w_rep_d       = '0;
               w_rep_first_d = 1'b1;
            end else if (r_cnt >= DEB_LAST) begin
               w_state_d         = StReleased;
               w_pressed_d       = 1'b0;
               w_release_pulse_d = 1'b1;
            end else begin
               w_cnt_d = w_cnt_inc;
            end
         end
         default: w_state_d = StReleased;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync1         <= 1'b1;
         r_sync2         <= 1'b1;
         r_state         <= StReleased;
         r_cnt           <= '0;
         r_rep           <= '0;
         r_rep_first     <= 1'b0;
         r_pressed       <= 1'b0;
         r_press_pulse   <= 1'b0;
         r_release_pulse <= 1'b0;
         r_step          <= 1'b0;
      end else begin
         r_sync1         <= i_key_n;
         r_sync2         <= r_sync1;
         r_state         <= w_state_d;
         r_cnt           <= w_cnt_d;
         r_rep           <= w_rep_d;
         r_rep_first     <= w_rep_first_d;
         r_pressed       <= w_pressed_d;
         r_press_pulse   <= w_press_pulse_d;
         r_release_pulse <= w_release_pulse_d;
         r_step          <= w_step_d;
      end
   end

   assign o_pressed       = r_pressed;
   assign o_press_pulse   = r_press_pulse;
   assign o_release_pulse = r_release_pulse;
   assign o_step          = r_step;

endmodule

// File: rtl/key_debouncer.sv
// Multi-key debouncer top: one independent key_channel per active-low board button.
module key_debouncer
   import key_pkg::*;
#(
   parameter int unsigned N_KEYS          = DEF_N_KEYS,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
   parameter int unsigned REPEAT_EN       = DEF_REPEAT_EN
) (
   input  logic              CLOCK_50,
   input  logic              RST,
   input  logic [N_KEYS-1:0] KEY,
   output logic [N_KEYS-1:0] PRESSED,
   output logic [N_KEYS-1:0] PRESS_PULSE,
   output logic [N_KEYS-1:0] RELEASE_PULSE,
   output logic [N_KEYS-1:0] STEP
);

   for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
      key_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD),
         .REPEAT_EN      (REPEAT_EN)
      ) u_ch (
         .i_clk          (CLOCK_50),
         .i_rst          (RST),
         .i_key_n        (KEY[g]),
         .o_pressed      (PRESSED[g]),
         .o_press_pulse  (PRESS_PULSE[g]),
         .o_release_pulse(RELEASE_PULSE[g]),
         .o_step         (STEP[g])
      );
   end

endmodule

// File: doc/key_debouncer.md
KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 SHALL have parameter N_KEYS, default 4: number of independent push-button channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000 (20 ms at 50 MHz): stable cycles required to accept a level change.
REQ-003 SHALL have parameter REPEAT_DELAY, default 25_000_000: held cycles before the first auto-repeat step.
REQ-004 SHALL have parameter REPEAT_PERIOD, default 10_000_000: cycles between subsequent auto-repeat steps.
REQ-005 SHALL have parameter REPEAT_EN, default 1: 0 disables auto-repeat.
REQ-006 SHALL have port CLOCK_50, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-007 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port KEY, input, N_KEYS bits: raw board buttons, active-low, asynchronous to CLOCK_50, bouncing.
REQ-009 SHALL have port PRESSED, output, N_KEYS bits: debounced level, active-high, 1 while the key is accepted as held.
REQ-010 SHALL have port PRESS_PULSE, output, N_KEYS bits: one-cycle pulse on each accepted press.
REQ-011 SHALL have port RELEASE_PULSE, output, N_KEYS bits: one-cycle pulse on each accepted release.
REQ-012 SHALL have port STEP, output, N_KEYS bits: one-cycle pulse on each press and on each auto-repeat tick; drives the downstream letter/digit advance.

Function
REQ-013 Each KEY bit SHALL pass through a 2-flop synchronizer, then be inverted to active-high before any other use.
REQ-014 Each channel SHALL run an independent FSM with states RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-015 RELEASED -> PRESS_WAIT when the synchronized key is 1; counter cleared on entry.
REQ-016 PRESS_WAIT: counter increments each cycle while the key is 1; key 0 -> RELEASED with no pulse.
REQ-017 PRESS_WAIT -> HELD when the counter reaches DEBOUNCE_CYCLES-1 with the key still 1; PRESSED rises, PRESS_PULSE and STEP pulse in the same cycle.
REQ-018 Press latency for a clean edge SHALL be exactly 2 + DEBOUNCE_CYCLES rising edges from the first edge sampling KEY low to PRESS_PULSE high.
REQ-019 HELD -> RELEASE_WAIT when the key is 0; the release debounce mirrors the press debounce.
REQ-020 RELEASE_WAIT -> RELEASED after DEBOUNCE_CYCLES stable 0 cycles; PRESSED falls and RELEASE_PULSE pulses; a 1 sample in between returns to HELD, keeps PRESSED high, emits no pulses, and restarts the repeat timing.
REQ-021 Auto-repeat, when REPEAT_EN=1: in HELD, STEP SHALL pulse REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles until HELD is left.
REQ-022 PRESS_PULSE, RELEASE_PULSE and STEP SHALL never exceed one cycle per event; PRESS_PULSE and RELEASE_PULSE never both high on one channel.
REQ-023 Counters SHALL be sized to clog2 of the largest cycle parameter, saturate, and never wrap.
REQ-024 Channels SHALL be fully independent; simultaneous presses on several keys produce simultaneous pulses.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 RST high SHALL asynchronously force every FSM to RELEASED, clear all counters and outputs to 0, and preset synchronizer flops to 1 (released).
REQ-027 A key held through reset deassertion SHALL be debounced normally and produce one PRESS_PULSE; RST mid-PRESS_WAIT or mid-HELD SHALL emit no RELEASE_PULSE.

Structure
REQ-028 A shared package key_pkg SHALL hold the FSM state enumeration and the default timing constants.
REQ-029 One sub-module key_channel (synchronizer, FSM, counters, one key) SHALL be instantiated N_KEYS times via generate.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, N_KEYS=4)
REQ-030 Clean press of KEY[0] held 30 cycles -> PRESS_PULSE[0] and STEP[0] at edge 6, STEP[0] again at edges 16, 19, 22, ...; PRESSED[0]=1 throughout.
REQ-031 KEY[1] bouncing low 2 cycles, high 1 cycle, repeated 5 times -> no pulses, PRESSED[1]=0.
REQ-032 Release after hold with a single 1-cycle high glitch in RELEASE_WAIT -> no RELEASE_PULSE until 4 stable released cycles; exactly one RELEASE_PULSE.
REQ-033 KEY[0] and KEY[3] pressed in the same cycle -> PRESS_PULSE = 4'b1001 in one cycle.
REQ-034 RST asserted while KEY[2] is HELD -> all outputs 0 immediately, no RELEASE_PULSE; key still held after RST deasserts -> one PRESS_PULSE[2] 6 edges later.
REQ-035 REPEAT_EN=0 with a 30-cycle hold -> exactly one STEP pulse.
